// File: rtl/stream_rr_arbiter.sv
// ============================================================================
// Module   : stream_rr_arbiter
// Brief    : Round-robin, burst-bounded arbiter of N valid/ready requesters
//            onto one registered output stream. SAMPLE_ARB_STATS_EN adds a
//            16-bit output handshake counter (beat_count_o).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          out_valid_o,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  input  logic                          out_ready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o
`ifdef SAMPLE_ARB_STATS_EN
  ,
  output logic [15:0]                   beat_count_o
`endif
);

  localparam int OW  = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST) + 1;
  localparam logic [BCW-1:0] C_LAST_BEAT = BCW'(MAX_BURST - 1);
  localparam logic [OW-1:0]  C_LAST_REQ  = OW'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [BCW-1:0]         burst_cnt_q, burst_cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;

  logic [DATA_WIDTH-1:0]  req_data_arr [NUM_REQ];
  logic [OW-1:0]          win_idx;
  logic                   win_found;
  logic [OW-1:0]          probe_idx;
  logic                   slot_free;
  logic                   owner_valid;
  logic                   xfer;

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_data_arr[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // First valid requester strictly after the last owner, wrapping to 0.
  always_comb begin
    win_idx   = owner_q;
    win_found = 1'b0;
    probe_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      probe_idx = OW'((int'(owner_q) + k) % NUM_REQ);
      if (!win_found && req_valid_i[probe_idx]) begin
        win_found = 1'b1;
        win_idx   = probe_idx;
      end
    end
  end

  assign slot_free   = !out_valid_q || out_ready_i;
  assign owner_valid = req_valid_i[owner_q];
  assign xfer        = (state_q == S_ACTIVE) && owner_valid && slot_free;
  assign req_ready_o = grant_q & {NUM_REQ{slot_free}};

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d     = S_ACTIVE;
          grant_d     = NUM_REQ'(1) << win_idx;
          owner_d     = win_idx;
          burst_cnt_d = '0;
        end
      end
      S_ACTIVE: begin
        if (xfer) begin
          if (burst_cnt_q == C_LAST_BEAT) begin
            state_d     = S_IDLE;
            grant_d     = '0;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + BCW'(1);
          end
        end else if (!owner_valid) begin
          state_d     = S_IDLE;
          grant_d     = '0;
          burst_cnt_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    // A new beat may replace a draining one in the same cycle.
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = req_data_arr[owner_q];
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      owner_q     <= C_LAST_REQ;
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q == S_ACTIVE);

`ifdef SAMPLE_ARB_STATS_EN
  logic [15:0] beat_count_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      beat_count_q <= '0;
    end else if (out_valid_q && out_ready_i) begin
      beat_count_q <= beat_count_q + 16'd1;
    end
  end

  assign beat_count_o = beat_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
// ============================================================================
// Module   : tb_stream_rr_arbiter
// Brief    : Randomized self-checking bench for stream_rr_arbiter against a
//            transaction-level reference model and beat scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_rr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*DW-1:0]    req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic [DW-1:0]            out_data;
  logic                     out_ready;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
`ifdef SAMPLE_ARB_STATS_EN
  logic [15:0]              beat_count;
`endif

  stream_rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DW),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ready_i (out_ready),
    .grant_o     (grant),
    .busy_o      (busy)
`ifdef SAMPLE_ARB_STATS_EN
    ,
    .beat_count_o(beat_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner as an integer, beats taken in the current grant,
  // and the beat currently held toward the datapath.
  bit             m_active;
  int             m_owner;
  int             m_last;
  int             m_beats;
  bit             m_ov;
  logic [DW-1:0]  m_od;
  int             m_bc;
  logic [DW-1:0]  sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] m_grant();
    logic [NUM_REQ-1:0] g;
    g = '0;
    if (m_active) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_owner  = 0;
    m_last   = NUM_REQ - 1;
    m_beats  = 0;
    m_ov     = 1'b0;
    m_od     = '0;
    m_bc     = 0;
    sb_q.delete();
  endtask

  task automatic compare_outputs();
    bit slot;
    slot = !m_ov || out_ready;
    check("grant", grant, m_grant());
    check("busy", busy, m_active);
    check("out_valid", out_valid, m_ov);
    check("out_data", out_data, m_od);
    check("req_ready", req_ready, slot ? m_grant() : '0);
`ifdef SAMPLE_ARB_STATS_EN
    check("beat_count", beat_count, m_bc);
`endif
  endtask

  task automatic model_advance();
    bit            slot;
    bit            xfer;
    bit            found;
    int            idx;
    logic [DW-1:0] exp_beat;
    slot = !m_ov || out_ready;
    xfer = m_active && req_valid[m_owner] && slot;

    if (m_ov && out_ready) begin
      m_bc = (m_bc + 1) % 65536;
      check("sb_depth", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
        exp_beat = sb_q.pop_front();
        check("sb_data", out_data, exp_beat);
      end
    end
    if (xfer) sb_q.push_back(req_data[m_owner*DW +: DW]);

    if (xfer) begin
      m_ov = 1'b1;
      m_od = req_data[m_owner*DW +: DW];
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end

    if (m_active) begin
      if (xfer) begin
        m_beats++;
        if (m_beats == MAX_BURST) m_active = 1'b0;
      end else if (!req_valid[m_owner]) begin
        m_active = 1'b0;
      end
    end else if (|req_valid) begin
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (m_last + k) % NUM_REQ;
        if (!found && req_valid[idx]) begin
          found   = 1'b1;
          m_owner = idx;
        end
      end
      m_active = 1'b1;
      m_last   = m_owner;
      m_beats  = 0;
    end
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*DW-1:0] d,
                      input logic rdy);
    req_valid = v;
    req_data  = d;
    out_ready = rdy;
    #1;
    compare_outputs();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [NUM_REQ*DW-1:0] rand_data();
    logic [NUM_REQ*DW-1:0] d;
    for (int i = 0; i < NUM_REQ; i++) d[i*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  initial begin
    logic [NUM_REQ-1:0]    v;
    logic [NUM_REQ*DW-1:0] d;
    logic [NUM_REQ-1:0]    prev_grant;
    int                    grant_log[$];
    int                    beats;
    int                    guard;

    req_data = '0;
    apply_reset();

    // First arbitration after reset picks requester 1 from 4'b1010.
    d = rand_data();
    d[1*DW +: DW] = 8'hA5;
    step(4'b1010, d, 1'b1);
    check("first_grant", grant, 4'b0010);
    step(4'b1010, d, 1'b1);
    check("first_data", out_data, 8'hA5);
    check("first_valid", out_valid, 1);

    // Backpressure: held beat stays, no ready while stalled.
    d[1*DW +: DW] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      step(4'b1010, d, 1'b0);
      check("bp_hold", out_data, 8'hA5);
      check("bp_ready", req_ready, 0);
    end
    step(4'b1010, d, 1'b1);
    check("bp_resume", out_data, 8'h5A);

    // Fairness: everyone valid, order must rotate 0,1,2,3,0 with full bursts.
    apply_reset();
    prev_grant = '0;
    beats      = 0;
    guard      = 0;
    while (grant_log.size() < 5 && guard < 60) begin
      step('1, rand_data(), 1'b1);
      guard++;
      if (grant != '0 && grant != prev_grant) begin
        for (int i = 0; i < NUM_REQ; i++) if (grant[i]) grant_log.push_back(i);
      end
      if (grant == '0 && prev_grant != '0) begin
        check("burst_len", beats, MAX_BURST);
        beats = 0;
      end
      if ((req_ready & req_valid) != '0) beats++;
      prev_grant = grant;
    end
    check("rr_count", grant_log.size(), 5);
    for (int i = 0; i < grant_log.size(); i++) check("rr_order", grant_log[i], i % NUM_REQ);

    // Randomized traffic with sticky valids and occasional async resets.
    v = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) if ($urandom_range(0, 3) == 0) v[i] = ~v[i];
      if ($urandom_range(0, 399) == 0) apply_reset();
      step(v, rand_data(), $urandom_range(0, 3) != 0);
    end

    // Reset while a beat is held must clear output and grant immediately.
    guard = 0;
    while (!m_ov && guard < 10) begin
      step('1, rand_data(), 1'b0);
      guard++;
    end
    check("pre_reset_valid", out_valid, m_ov);
    check("pre_reset_model_ov", m_ov, 1);
    apply_reset();
    step('0, rand_data(), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
